// File: rtl/rf_write_scheduler.sv
// Register-file write-port arbiter: in-order writeback has priority over one
// long-latency unit, with a per-register pending scoreboard and starvation flag.
module rf_write_scheduler #(
  parameter int STARVE_LIMIT = 4,
  parameter int ADDR_W       = 5,
  parameter int DATA_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              lu_valid,
  input  logic [ADDR_W-1:0] lu_addr,
  input  logic [DATA_W-1:0] lu_data,
  output logic              lu_ready,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_addr,
  output logic              issue_conflict,
  input  logic [ADDR_W-1:0] query_addr1,
  input  logic [ADDR_W-1:0] query_addr2,
  output logic              busy1,
  output logic              busy2,
  output logic              lu_starved,
  output logic              rf_write_enable,
  output logic [ADDR_W-1:0] rf_addr_write,
  output logic [DATA_W-1:0] rf_in
);

  localparam int NREG  = 1 << ADDR_W;
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [NREG-1:0]  pending;
  logic [NREG-1:0]  pending_nxt;
  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] starve_nxt;
  logic             wb_req;
  logic             lu_req;

  always_comb begin
    wb_req = wb_valid && (wb_addr != '0);
    lu_req = lu_valid && (lu_addr != '0);

    // A writeback to x0 is not a request, so the lu result may take the port.
    lu_ready        = !reset && !wb_req && lu_valid;
    rf_write_enable = !reset && (wb_req || (lu_ready && lu_req));
    if (!wb_req && lu_valid) begin
      rf_addr_write = lu_addr;
      rf_in         = lu_data;
    end else begin
      rf_addr_write = wb_addr;
      rf_in         = wb_data;
    end

    issue_conflict = issue_valid && (issue_addr != '0) && pending[issue_addr];
    busy1          = pending[query_addr1];
    busy2          = pending[query_addr2];

    // Clear applied before set so a same-cycle set wins.
    pending_nxt = pending;
    if (lu_valid && lu_ready)
      pending_nxt[lu_addr] = 1'b0;
    if (issue_valid && (issue_addr != '0) && !issue_conflict)
      pending_nxt[issue_addr] = 1'b1;
    pending_nxt[0] = 1'b0;

    if (lu_valid && !lu_ready)
      starve_nxt = (starve_cnt == CNT_MAX) ? starve_cnt : starve_cnt + 1'b1;
    else
      starve_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending    <= '0;
      starve_cnt <= '0;
      lu_starved <= 1'b0;
    end else begin
      pending    <= pending_nxt;
      starve_cnt <= starve_nxt;
      lu_starved <= (starve_nxt == CNT_MAX);
    end
  end

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Bench for rf_write_scheduler: directed scenarios then randomized traffic,
// checked against a set-of-pending-registers model and a blocked-run counter.
module tb_rf_write_scheduler;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        lu_valid;
  logic [4:0]  lu_addr;
  logic [31:0] lu_data;
  logic        lu_ready;
  logic        issue_valid;
  logic [4:0]  issue_addr;
  logic        issue_conflict;
  logic [4:0]  query_addr1;
  logic [4:0]  query_addr2;
  logic        busy1;
  logic        busy2;
  logic        lu_starved;
  logic        rf_write_enable;
  logic [4:0]  rf_addr_write;
  logic [31:0] rf_in;

  always #5 clk = ~clk;

  rf_write_scheduler #(
    .STARVE_LIMIT(LIMIT),
    .ADDR_W(5),
    .DATA_W(32)
  ) dut (
    .clk(clk),
    .reset(reset),
    .wb_valid(wb_valid),
    .wb_addr(wb_addr),
    .wb_data(wb_data),
    .lu_valid(lu_valid),
    .lu_addr(lu_addr),
    .lu_data(lu_data),
    .lu_ready(lu_ready),
    .issue_valid(issue_valid),
    .issue_addr(issue_addr),
    .issue_conflict(issue_conflict),
    .query_addr1(query_addr1),
    .query_addr2(query_addr2),
    .busy1(busy1),
    .busy2(busy2),
    .lu_starved(lu_starved),
    .rf_write_enable(rf_write_enable),
    .rf_addr_write(rf_addr_write),
    .rf_in(rf_in)
  );

  int checks = 0;
  int errors = 0;
  bit pend[int];       // registers with an outstanding long-latency result
  int blocked_run = 0; // consecutive cycles the lu result has been refused
  bit last_blocked = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_pend(input logic [4:0] a);
    return (a != 5'd0) && pend.exists(int'(a));
  endfunction

  task automatic idle();
    wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
    lu_valid = 1'b0; lu_addr = '0; lu_data = '0;
    issue_valid = 1'b0; issue_addr = '0;
    query_addr1 = '0; query_addr2 = '0;
  endtask

  // Inputs are set at the negedge; combinational outputs are checked 1 time
  // unit later, then the model advances across the posedge.
  task automatic cycle();
    bit wb_claims, acc, we, conf;
    #1;
    wb_claims = wb_valid && (wb_addr != 5'd0);
    acc  = !reset && !wb_claims && lu_valid;
    we   = !reset && (wb_claims || (acc && lu_addr != 5'd0));
    conf = issue_valid && is_pend(issue_addr);
    chk("lu_ready", 32'(lu_ready), 32'(acc));
    chk("rf_write_enable", 32'(rf_write_enable), 32'(we));
    if (we) begin
      chk("rf_addr_write", 32'(rf_addr_write), wb_claims ? 32'(wb_addr) : 32'(lu_addr));
      chk("rf_in", rf_in, wb_claims ? wb_data : lu_data);
    end
    chk("issue_conflict", 32'(issue_conflict), 32'(conf));
    chk("busy1", 32'(busy1), 32'(is_pend(query_addr1)));
    chk("busy2", 32'(busy2), 32'(is_pend(query_addr2)));
    @(posedge clk);
    if (reset) begin
      pend.delete();
      blocked_run  = 0;
      last_blocked = 1'b0;
    end else begin
      if (acc && pend.exists(int'(lu_addr)))
        pend.delete(int'(lu_addr));
      if (issue_valid && issue_addr != 5'd0 && !conf)
        pend[int'(issue_addr)] = 1'b1;
      last_blocked = lu_valid && !acc;
      blocked_run  = last_blocked ? blocked_run + 1 : 0;
    end
    #1;
    chk("lu_starved", 32'(lu_starved), 32'(blocked_run >= LIMIT));
    @(negedge clk);
  endtask

  initial begin
    idle();
    reset = 1'b1;
    @(negedge clk);
    cycle();
    cycle();
    reset = 1'b0;

    // Lone lu result
    idle(); query_addr1 = 5'd5; cycle();
    idle(); issue_valid = 1'b1; issue_addr = 5'd5; cycle();
    idle(); query_addr1 = 5'd5; cycle();
    idle(); lu_valid = 1'b1; lu_addr = 5'd5; lu_data = 32'd77; query_addr1 = 5'd5; cycle();
    idle(); query_addr1 = 5'd5; cycle();

    // Collision: writeback wins, lu goes next cycle
    idle(); issue_valid = 1'b1; issue_addr = 5'd7; cycle();
    idle(); wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'd11;
    lu_valid = 1'b1; lu_addr = 5'd7; lu_data = 32'd22; query_addr2 = 5'd7; cycle();
    wb_valid = 1'b0; cycle();
    idle(); query_addr2 = 5'd7; cycle();

    // Starvation
    idle(); issue_valid = 1'b1; issue_addr = 5'd9; cycle();
    idle(); lu_valid = 1'b1; lu_addr = 5'd9; lu_data = 32'd99;
    wb_valid = 1'b1; wb_addr = 5'd4; wb_data = 32'h44;
    for (int i = 0; i < 6; i++) cycle();
    wb_valid = 1'b0; cycle();
    idle(); query_addr1 = 5'd9; cycle();

    // x0 cases
    idle(); issue_valid = 1'b1; issue_addr = 5'd0; query_addr1 = 5'd0; cycle();
    idle(); issue_valid = 1'b1; issue_addr = 5'd8; cycle();
    idle(); wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'h5;
    lu_valid = 1'b1; lu_addr = 5'd8; lu_data = 32'h88; cycle();
    idle(); lu_valid = 1'b1; lu_addr = 5'd0; lu_data = 32'hdead; cycle();

    // WAW and same-cycle issue/clear
    idle(); issue_valid = 1'b1; issue_addr = 5'd6; cycle();
    idle(); issue_valid = 1'b1; issue_addr = 5'd6; query_addr1 = 5'd6; cycle();
    idle(); issue_valid = 1'b1; issue_addr = 5'd6;
    lu_valid = 1'b1; lu_addr = 5'd6; lu_data = 32'h66; cycle();
    idle(); query_addr1 = 5'd6; cycle();

    // Mid-operation reset
    idle(); issue_valid = 1'b1; issue_addr = 5'd2; cycle();
    idle(); issue_valid = 1'b1; issue_addr = 5'd10; cycle();
    idle(); query_addr1 = 5'd2; query_addr2 = 5'd10;
    lu_valid = 1'b1; lu_addr = 5'd12; lu_data = 32'h12;
    wb_valid = 1'b1; wb_addr = 5'd1; wb_data = 32'h1;
    for (int i = 0; i < 3; i++) cycle();
    reset = 1'b1; cycle();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    wb_valid = 1'b0; cycle();
    idle(); query_addr1 = 5'd2; query_addr2 = 5'd10; cycle();

    // Randomized traffic over a small register range to provoke hits
    for (int n = 0; n < 400; n++) begin
      reset       = ($urandom_range(0, 63) == 0);
      wb_valid    = ($urandom_range(0, 1) == 1);
      wb_addr     = 5'($urandom_range(0, 7));
      wb_data     = $urandom;
      issue_valid = ($urandom_range(0, 2) == 0);
      issue_addr  = 5'($urandom_range(0, 7));
      query_addr1 = 5'($urandom_range(0, 7));
      query_addr2 = 5'($urandom_range(0, 7));
      if (!last_blocked) begin
        lu_valid = ($urandom_range(0, 1) == 1);
        lu_addr  = 5'($urandom_range(0, 7));
        lu_data  = $urandom;
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_write_scheduler.md
Name: rf_write_scheduler

Overview:
- Shares the single register-file write port between two sources: the in-order pipeline writeback stage, and one long-latency unit (mul/div, or a load miss) that returns results out of order.
- Holds a per-register pending scoreboard so the hazard unit can stall decode on registers with an outstanding long-latency result.
- Sits between the writeback stage, the long-latency unit, the hazard unit and the register file.

Parameters:
- STARVE_LIMIT, 4, consecutive cycles the long-latency result may wait before lu_starved asserts (must be ≥1).
- ADDR_W, 5, width of a RegAddress.
- DATA_W, 32, width of a Word.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- wb_valid  in  1  writeback stage has a result this cycle (cannot be back-pressured)
- wb_addr  in  ADDR_W  writeback destination
- wb_data  in  DATA_W  writeback value
- lu_valid  in  1  long-latency unit result available
- lu_addr  in  ADDR_W  long-latency destination
- lu_data  in  DATA_W  long-latency value
- lu_ready  out  1  long-latency result accepted this cycle
- issue_valid  in  1  decode issues a long-latency op this cycle
- issue_addr  in  ADDR_W  its destination
- issue_conflict  out  1  issue_addr already pending (WAW); decode must not issue
- query_addr1  in  ADDR_W  decode source 1
- query_addr2  in  ADDR_W  decode source 2
- busy1  out  1  query_addr1 pending
- busy2  out  1  query_addr2 pending
- lu_starved  out  1  request to hazard unit to insert one writeback bubble
- rf_write_enable  out  1  to register-file write_enable
- rf_addr_write  out  ADDR_W  to register-file addr_write
- rf_in  out  DATA_W  to register-file in

Behaviour:
- The block has one clock, clk. Reset is synchronous and active-high, on the port reset. Polarity and synchronicity are fixed.
- State:
  - pending[31:1]: register x0 is never pending.
  - starve_cnt: saturating at STARVE_LIMIT.
  - lu_starved: registered.
- Reset (evaluated at the clk edge while reset=1):
  - pending and starve_cnt cleared; lu_starved=0.
  - While reset=1, lu_ready=0 and rf_write_enable=0 combinationally.
- wb_req = wb_valid && wb_addr!=0. lu_req = lu_valid && lu_addr!=0.
- Arbitration (combinational, zero latency):
  - wb_req=1: port carries the writeback; lu_ready=0.
  - Otherwise, lu_valid=1: lu_ready=1; port carries the lu result; rf_write_enable=lu_req.
  - Otherwise: rf_write_enable=0. rf_addr_write and rf_in are don't-care but driven from the wb fields.
- An lu result to x0 is accepted and discarded (lu_ready=1, no write) whenever the writeback does not claim the port.
- Writeback to x0 is not a request; a simultaneous lu result takes the port.
- Scoreboard, updated at the clk edge:
  - Set: issue_valid && issue_addr!=0 && !issue_conflict sets pending[issue_addr].
  - Clear: lu_valid && lu_ready clears pending[lu_addr].
  - Set and clear of the same address in one cycle: the bit ends set.
  - issue_conflict = issue_valid && issue_addr!=0 && pending[issue_addr]. It uses the current bit only; a same-cycle clear does not suppress it.
  - busy1/busy2 = pending[query_addr] (0 for x0), combinational from current state.
  - The bit clears on the same edge the register file stores the value. A read in the following cycle sees busy=0 and the new value. No bypass is provided.
- A writeback to a pending register is permitted and does not touch pending. Ordering is the hazard unit's responsibility.
- Starvation:
  - starve_cnt increments when lu_valid && !lu_ready.
  - It returns to 0 when lu_ready=1 or lu_valid=0, and saturates at STARVE_LIMIT.
  - lu_starved is registered: next = (next starve_cnt == STARVE_LIMIT). It stays high until the lu result is accepted; it deasserts the cycle after acceptance.
- lu_valid/lu_addr/lu_data must stay stable while lu_valid && !lu_ready. The block does not check this.

Test Plan:
- Lone lu result: after reset, issue x5 (busy1 with query_addr1=5 → 1 next cycle), then lu_valid x5=77 with wb idle → lu_ready=1, rf write x5=77, busy1=0 next cycle.
- Collision: wb_valid x3=11 and lu_valid x7=22 in the same cycle → port writes x3=11, lu_ready=0. Next cycle wb idle → x7=22 written, pending[7] cleared.
- Starvation: issue x9, then lu_valid with wb_valid x4 held high for 6 cycles, STARVE_LIMIT=4 → lu_starved rises after the 4th blocked edge. wb drops → lu accepted; lu_starved=0 the following cycle.
- x0 cases:
  - issue x0 → no pending, issue_conflict=0.
  - wb_valid x0 plus lu_valid x8 → x8 written.
  - lu result for x0 accepted with no write.
- WAW / same-cycle: issue x6 twice → second issue_conflict=1. Issue x6 on the same cycle x6's lu result is accepted → issue_conflict=1, bit cleared.
- Mid-operation reset: pending {x2,x10}, starve_cnt=3, assert reset one cycle → all busy=0, lu_starved=0, rf_write_enable=0 during reset, counter restarts from 0.
